muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_W, default 32: operand width; HI and LO are each DATA_W bits.
REQ-002 Parameter MUL_LAT, default 2, legal range 1..4: multiply latency in cycles.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  request an operation; accepted only when ready_o=1.
REQ-006 cancel_i  input  1  flush; abandons any operation in flight.
REQ-007 op_i  input  3  operation: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU.
REQ-008 opdata1_i  input  DATA_W  multiplicand or dividend.
REQ-009 opdata2_i  input  DATA_W  multiplier or divisor.
REQ-010 hilo_i  input  2*DATA_W  current {HI,LO} accumulator, already forwarded by the caller.
REQ-011 ready_o  output  1  unit idle; start_i is accepted this cycle.
REQ-012 valid_o  output  1  result_o is valid; one-cycle pulse.
REQ-013 result_o  output  2*DATA_W  {HI,LO} value to write.
REQ-014 div_by_zero_o  output  1  qualifies valid_o; the completed DIV/DIVU had a zero divisor.

Function
REQ-015 The FSM SHALL have four states: IDLE, MUL, DIV, DONE; ready_o=1 only in IDLE.
REQ-016 The acceptance edge SHALL be: IDLE, start_i=1, cancel_i=0; opdata1_i, opdata2_i, op_i and hilo_i are registered on this edge.
REQ-017 start_i SHALL be ignored outside IDLE.
REQ-018 For a multiply-class op, valid_o SHALL assert exactly MUL_LAT cycles after the acceptance edge; with MUL_LAT=1 the FSM goes IDLE->DONE directly.
REQ-019 For DIV/DIVU with a nonzero divisor, the FSM SHALL spend exactly DATA_W cycles in DIV at one quotient bit per cycle, restoring; valid_o asserts DATA_W+1 cycles after acceptance.
REQ-020 For DIV/DIVU with a zero divisor, the FSM SHALL go IDLE->DONE, with result_o=0 and div_by_zero_o=1 while valid_o=1.
REQ-021 DONE SHALL last one cycle (valid_o=1), then return to IDLE.
REQ-022 Signed ops (MULT, MADD, MSUB, DIV) SHALL operate on the operand magnitudes and negate the result by sign, as follows.
REQ-023 Product sign SHALL be sign1^sign2; quotient sign SHALL be sign1^sign2; remainder sign SHALL follow the dividend.
REQ-024 Multiply results: MULT/MULTU give the 2*DATA_W product; MADD/MADDU give hilo+product; MSUB/MSUBU give hilo-product. All sums are modulo 2^(2*DATA_W) with no overflow flag.
REQ-025 Divide result SHALL be HI=remainder, LO=quotient.
REQ-026 Signed divide of most-negative by -1 SHALL yield LO=most-negative and HI=0.
REQ-027 When cancel_i=1, the next state SHALL be IDLE from any state, with no valid_o; cancel_i overrides a simultaneous start_i.
REQ-028 valid_o SHALL NOT assert in the cycle cancel_i=1, even when the FSM is in DONE.
REQ-029 result_o and div_by_zero_o SHALL be 0 whenever valid_o=0.
REQ-030 A new op MAY be accepted on the cycle after DONE; there is no back-to-back acceptance during DONE.

Reset
REQ-031 While rst=0 at a clock edge, the FSM SHALL go to IDLE and clear all internal registers and counters.
REQ-032 After reset, outputs SHALL be ready_o=1, valid_o=0, result_o=0, div_by_zero_o=0.
REQ-033 Reset mid-operation SHALL discard the operation with no valid_o.

Structure
REQ-034 A shared package SHALL hold the op_i encodings, the FSM state typedef and the DATA_W default.
REQ-035 The iterative divider (magnitude in, quotient/remainder out, bit counter) SHALL be a sub-module named div_core.
REQ-036 The multiplier SHALL be a MUL_LAT-deep register pipeline around one multiply; no vendor IP.

Verification
REQ-037 MULT 0xFFFFFFFE x 0x00000003, MUL_LAT=2 -> valid_o 2 cycles after accept, result_o=0xFFFFFFFF_FFFFFFFA.
REQ-038 MADDU, hilo=0x00000000_FFFFFFFF, 1 x 1 -> result_o=0x00000001_00000000.
REQ-039 DIV 0xFFFFFFF9 (-7) / 2 -> valid_o at accept+33, HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-040 DIVU x / 0 -> valid_o 1 cycle after accept, div_by_zero_o=1, result_o=0.
REQ-041 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-042 DIVU started, cancel_i at cycle 10 together with start_i -> no valid_o, ready_o=1 next cycle, start not accepted; repeat with rst=0 mid-DIV -> same.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// muldiv_unit_pkg : op encodings, FSM state type and width defaults
// Revision        : 1.0
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_MADD  = 3'd2,
      OP_MADDU = 3'd3,
      OP_MSUB  = 3'd4,
      OP_MSUBU = 3'd5,
      OP_DIV   = 3'd6,
      OP_DIVU  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // op_i[2:1] selects the operation class; op_i[0]=1 marks the unsigned variant
   localparam logic [1:0] CLS_MUL  = 2'b00;
   localparam logic [1:0] CLS_MADD = 2'b01;
   localparam logic [1:0] CLS_MSUB = 2'b10;
   localparam logic [1:0] CLS_DIV  = 2'b11;

   function automatic logic op_is_signed(input logic [2:0] op);
      return ~op[0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_div_core.sv
// ============================================================================
// div_core : restoring unsigned divider, one quotient bit per cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_core #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              cancel_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic              last_o,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dsr_q, dsr_d;
   logic [DATA_W:0]   shifted_w, diff_w;

   always_comb begin
      shifted_w = {rem_q, quo_q[DATA_W-1]};
      diff_w    = shifted_w - {1'b0, dsr_q};
      last_o    = busy_q && (cnt_q == CNT_LAST);
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dsr_d     = dsr_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         quo_d  = dividend_i;
         rem_d  = '0;
         dsr_d  = divisor_i;
      end else if (busy_q) begin
         // A borrow out of the trial subtraction restores the shifted remainder
         rem_d = diff_w[DATA_W] ? shifted_w[DATA_W-1:0] : diff_w[DATA_W-1:0];
         quo_d = {quo_q[DATA_W-2:0], ~diff_w[DATA_W]};
         cnt_d = cnt_q + CNT_W'(1);
         if (last_o) busy_d = 1'b0;
      end
      if (cancel_i) busy_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : HI/LO multiply, multiply-accumulate and iterative divide unit
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MUL_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                cancel_i,
   input  logic [2:0]          op_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic [2*DATA_W-1:0] hilo_i,
   output logic                ready_o,
   output logic                valid_o,
   output logic [2*DATA_W-1:0] result_o,
   output logic                div_by_zero_o
);
   localparam logic [2:0] MUL_LAST = 3'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);

   state_e              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [1:0]          cls_q, cls_d;
   logic                sign1_q, sign1_d, sign2_q, sign2_d, dbz_q, dbz_d;
   logic [DATA_W-1:0]   mag1_q, mag1_d, mag2_q, mag2_d;
   logic [2*DATA_W-1:0] hilo_q, hilo_d;

   logic                sign1_w, sign2_w, accept_w, div_zero_w, div_start_w, div_last_w;
   logic [DATA_W-1:0]   mag1_w, mag2_w, quo_mag_w, rem_mag_w, quo_w, rem_w;
   logic [2*DATA_W-1:0] prod_w, mul_mag_w, mul_signed_w, mul_res_w, final_w;

   always_comb begin
      sign1_w     = op_is_signed(op_i) & opdata1_i[DATA_W-1];
      sign2_w     = op_is_signed(op_i) & opdata2_i[DATA_W-1];
      mag1_w      = sign1_w ? -opdata1_i : opdata1_i;
      mag2_w      = sign2_w ? -opdata2_i : opdata2_i;
      div_zero_w  = (opdata2_i == '0);
      accept_w    = (state_q == S_IDLE) && start_i && !cancel_i;
      div_start_w = accept_w && (op_i[2:1] == CLS_DIV) && !div_zero_w;

      state_d = state_q;
      cnt_d   = cnt_q;
      cls_d   = cls_q;
      sign1_d = sign1_q;
      sign2_d = sign2_q;
      dbz_d   = dbz_q;
      mag1_d  = mag1_q;
      mag2_d  = mag2_q;
      hilo_d  = hilo_q;

      case (state_q)
         S_IDLE: begin
            if (accept_w) begin
               cls_d   = op_i[2:1];
               sign1_d = sign1_w;
               sign2_d = sign2_w;
               mag1_d  = mag1_w;
               mag2_d  = mag2_w;
               hilo_d  = hilo_i;
               dbz_d   = (op_i[2:1] == CLS_DIV) && div_zero_w;
               cnt_d   = '0;
               if (op_i[2:1] == CLS_DIV) state_d = div_zero_w ? S_DONE : S_DIV;
               else                      state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
            end
         end
         S_MUL: begin
            if (cnt_q == MUL_LAST) state_d = S_DONE;
            else                   cnt_d   = cnt_q + 3'd1;
         end
         S_DIV: begin
            if (div_last_w) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (cancel_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cls_q   <= '0;
         sign1_q <= 1'b0;
         sign2_q <= 1'b0;
         dbz_q   <= 1'b0;
         mag1_q  <= '0;
         mag2_q  <= '0;
         hilo_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cls_q   <= cls_d;
         sign1_q <= sign1_d;
         sign2_q <= sign2_d;
         dbz_q   <= dbz_d;
         mag1_q  <= mag1_d;
         mag2_q  <= mag2_d;
         hilo_q  <= hilo_d;
      end
   end

   // The operand registers form the first stage; MUL_LAT-1 product stages follow
   assign prod_w = {{DATA_W{1'b0}}, mag1_q} * {{DATA_W{1'b0}}, mag2_q};

   generate
      if (MUL_LAT > 1) begin : g_mul_pipe
         logic [2*DATA_W-1:0] stage_q [MUL_LAT-1];
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int i = 0; i < MUL_LAT - 1; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= prod_w;
               for (int i = 1; i < MUL_LAT - 1; i++) stage_q[i] <= stage_q[i-1];
            end
         end
         assign mul_mag_w = stage_q[MUL_LAT-2];
      end else begin : g_mul_comb
         assign mul_mag_w = prod_w;
      end
   endgenerate

   div_core #(
      .DATA_W (DATA_W)
   ) u_div_core (
      .clk         (clk),
      .rst         (rst),
      .start_i     (div_start_w),
      .cancel_i    (cancel_i),
      .dividend_i  (mag1_w),
      .divisor_i   (mag2_w),
      .last_o      (div_last_w),
      .quotient_o  (quo_mag_w),
      .remainder_o (rem_mag_w)
   );

   always_comb begin
      mul_signed_w = (sign1_q ^ sign2_q) ? -mul_mag_w : mul_mag_w;
      case (cls_q)
         CLS_MADD: mul_res_w = hilo_q + mul_signed_w;
         CLS_MSUB: mul_res_w = hilo_q - mul_signed_w;
         default:  mul_res_w = mul_signed_w;
      endcase
      quo_w = (sign1_q ^ sign2_q) ? -quo_mag_w : quo_mag_w;
      rem_w = sign1_q ? -rem_mag_w : rem_mag_w;
      if (dbz_q)                 final_w = '0;
      else if (cls_q == CLS_DIV) final_w = {rem_w, quo_w};
      else                       final_w = mul_res_w;

      ready_o       = (state_q == S_IDLE);
      valid_o       = (state_q == S_DONE) && !cancel_i;
      result_o      = valid_o ? final_w : '0;
      div_by_zero_o = valid_o & dbz_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed and randomized checks of muldiv_unit
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int DATA_W  = 32;
   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        cancel_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic [63:0] hilo_i = '0;
   logic        ready_o, valid_o, div_by_zero_o;
   logic [63:0] result_o;

   int vectors = 0;
   int miscompares = 0;

   muldiv_unit #(
      .DATA_W  (DATA_W),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .cancel_i      (cancel_i),
      .op_i          (op_i),
      .opdata1_i     (opdata1_i),
      .opdata2_i     (opdata2_i),
      .hilo_i        (hilo_i),
      .ready_o       (ready_o),
      .valid_o       (valid_o),
      .result_o      (result_o),
      .div_by_zero_o (div_by_zero_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic straight from the HI/LO rules using native integer ops
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] hilo, output logic [63:0] res,
                                 output logic dbz, output int lat);
      logic [63:0] sp, up;
      int sa, sb;
      sa  = a;
      sb  = b;
      sp  = 64'(longint'(sa) * longint'(sb));
      up  = {32'd0, a} * {32'd0, b};
      res = '0;
      dbz = 1'b0;
      lat = MUL_LAT;
      case (op)
         OP_MULT:  res = sp;
         OP_MULTU: res = up;
         OP_MADD:  res = hilo + sp;
         OP_MADDU: res = hilo + up;
         OP_MSUB:  res = hilo - sp;
         OP_MSUBU: res = hilo - up;
         OP_DIV: begin
            if (b == 32'd0) begin
               dbz = 1'b1;
               lat = 1;
            end else begin
               lat = DATA_W + 1;
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
               else res = {32'(sa % sb), 32'(sa / sb)};
            end
         end
         default: begin
            if (b == 32'd0) begin
               dbz = 1'b1;
               lat = 1;
            end else begin
               lat = DATA_W + 1;
               res = {a % b, a / b};
            end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'($urandom_range(1, 9));
         2:       return ~32'($urandom_range(0, 8));
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] hilo,
                         input logic [63:0] exp_res, input logic exp_dbz, input int exp_lat);
      int k;
      bit seen;
      @(negedge clk);
      check({tag, "/ready_idle"}, 64'(ready_o), 64'd1);
      op_i      = op;
      opdata1_i = a;
      opdata2_i = b;
      hilo_i    = hilo;
      start_i   = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 100) begin
         @(negedge clk);
         k++;
         if (valid_o) seen = 1'b1;
         else if (k == 1) begin
            check({tag, "/ready_busy"}, 64'(ready_o), 64'd0);
            check({tag, "/res_quiet"}, result_o, 64'd0);
         end
      end
      check({tag, "/latency"}, 64'(k), 64'(exp_lat));
      check({tag, "/result"}, result_o, exp_res);
      check({tag, "/dbz"}, 64'(div_by_zero_o), 64'(exp_dbz));
   endtask

   task automatic watch_quiet(input string tag, input int n);
      int busy_cnt;
      int valid_cnt;
      busy_cnt  = 0;
      valid_cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (!ready_o) busy_cnt++;
         if (valid_o)  valid_cnt++;
      end
      check({tag, "/no_accept"}, 64'(busy_cnt), 64'd0);
      check({tag, "/no_valid"}, 64'(valid_cnt), 64'd0);
   endtask

   task automatic abort_div(input string tag, input bit use_rst);
      @(negedge clk);
      op_i      = OP_DIVU;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (10) @(negedge clk);
      op_i    = OP_MULTU;
      start_i = 1'b1;
      if (use_rst) rst = 1'b0;
      else         cancel_i = 1'b1;
      #1 check({tag, "/valid_abort"}, 64'(valid_o), 64'd0);
      @(negedge clk);
      start_i  = 1'b0;
      cancel_i = 1'b0;
      rst      = 1'b1;
      check({tag, "/ready_next"}, 64'(ready_o), 64'd1);
      check({tag, "/valid_next"}, 64'(valid_o), 64'd0);
      watch_quiet(tag, 40);
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;
      logic [63:0] r_hilo, e_res;
      logic        e_dbz;
      int          e_lat;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset/ready", 64'(ready_o), 64'd1);
      check("reset/valid", 64'(valid_o), 64'd0);
      check("reset/result", result_o, 64'd0);
      check("reset/dbz", 64'(div_by_zero_o), 64'd0);
      rst = 1'b1;

      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 2);
      run_op("maddu_carry", OP_MADDU, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF,
             64'h0000_0001_0000_0000, 1'b0, 2);
      run_op("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);
      run_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, 64'hDEAD_BEEF_0000_0001,
             64'd0, 1'b1, 1);
      run_op("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,
             64'h0000_0000_8000_0000, 1'b0, 33);
      run_op("msub_signed", OP_MSUB, 32'hFFFF_FFFF, 32'd5, 64'd10,
             64'd15, 1'b0, 2);

      abort_div("cancel_div", 1'b0);
      abort_div("reset_div", 1'b1);

      // Cancel arriving while the result is being presented must suppress it
      @(negedge clk);
      op_i      = OP_MULTU;
      opdata1_i = 32'd3;
      opdata2_i = 32'd4;
      start_i   = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (MUL_LAT) @(negedge clk);
      check("cancel_done/pre_valid", 64'(valid_o), 64'd1);
      cancel_i = 1'b1;
      #1;
      check("cancel_done/valid", 64'(valid_o), 64'd0);
      check("cancel_done/result", result_o, 64'd0);
      @(negedge clk);
      cancel_i = 1'b0;
      check("cancel_done/ready", 64'(ready_o), 64'd1);

      for (int n = 0; n < 48; n++) begin
         r_op   = 3'($urandom_range(0, 7));
         r_a    = pick();
         r_b    = pick();
         r_hilo = {$urandom, $urandom};
         model(r_op, r_a, r_b, r_hilo, e_res, e_dbz, e_lat);
         run_op($sformatf("rand%0d_op%0d", n, r_op), r_op, r_a, r_b, r_hilo, e_res, e_dbz, e_lat);
      end

      @(negedge clk);
      check("final/ready", 64'(ready_o), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
